// File: rtl/data_memory.sv
// Word-organised data memory for the multi-cycle MIPS datapath: one load/store at a time,
// programmable wait states, byte/half/word lanes (little-endian) and misalignment flagging.
module data_memory #(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_mem_read,
   input  logic        i_mem_write,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_write_data,
   input  logic [1:0]  i_size,
   input  logic        i_load_unsigned,
   output logic [31:0] o_read_data,
   output logic        o_ready,
   output logic        o_error
);
   // state  | meaning
   // IDLE   | waiting for a request; inputs sampled
   // BUSY   | wait states counting down; captured request used
   // DONE   | ready pulse; read_data/error valid
   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

   state_t        r_state, w_next;
   logic [CW-1:0] r_cnt;
   logic [AW+1:0] r_addr;
   logic [31:0]   r_wdata;
   logic [1:0]    r_size;
   logic          r_unsigned;
   logic          r_is_write;
   logic [31:0]   r_read_data;
   logic [31:0]   r_mem [DEPTH_WORDS];

   logic          w_req, w_idle, w_enter_done, w_mis;
   logic [AW+1:0] w_addr;
   logic [AW-1:0] w_idx;
   logic [31:0]   w_wdata, w_wword, w_word, w_load;
   logic [1:0]    w_size;
   logic          w_unsigned, w_is_write;
   logic [3:0]    w_be;
   logic [7:0]    w_byte;
   logic [15:0]   w_half;
   logic          w_unused_addr;

   function automatic logic misaligned(input logic [1:0] s, input logic [1:0] a);
      return (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a != 2'b00);
   endfunction

   assign w_unused_addr = ^i_addr[31:AW+2];
   assign w_req  = i_mem_read | i_mem_write;
   assign w_idle = (r_state == S_IDLE);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_req) w_next = (WAIT_CYCLES == 0) ? S_DONE : S_BUSY;
         S_BUSY:  if (r_cnt == CW'(1)) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // With zero wait states the commit edge is also the acceptance edge, so the live inputs are used.
   assign w_enter_done = (w_next == S_DONE) && (r_state != S_DONE);
   assign w_addr       = w_idle ? i_addr[AW+1:0]  : r_addr;
   assign w_wdata      = w_idle ? i_write_data    : r_wdata;
   assign w_size       = w_idle ? i_size          : r_size;
   assign w_unsigned   = w_idle ? i_load_unsigned : r_unsigned;
   assign w_is_write   = w_idle ? i_mem_write     : r_is_write;
   assign w_idx        = w_addr[AW+1:2];
   assign w_mis        = misaligned(w_size, w_addr[1:0]);

   always_comb begin
      w_be    = 4'b1111;
      w_wword = w_wdata;
      case (w_size)
         2'b00: begin
            w_be    = 4'b0001 << w_addr[1:0];
            w_wword = {4{w_wdata[7:0]}};
         end
         2'b01: begin
            w_be    = w_addr[1] ? 4'b1100 : 4'b0011;
            w_wword = {2{w_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   assign w_word = r_mem[w_idx];
   assign w_byte = w_word[{w_addr[1:0], 3'b000} +: 8];
   assign w_half = w_addr[1] ? w_word[31:16] : w_word[15:0];

   always_comb begin
      w_load = w_word;
      case (w_size)
         2'b00:   w_load = {{24{~w_unsigned & w_byte[7]}}, w_byte};
         2'b01:   w_load = {{16{~w_unsigned & w_half[15]}}, w_half};
         default: w_load = w_word;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst && w_enter_done && w_is_write && !w_mis) begin
         for (int b = 0; b < 4; b++)
            if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt       <= '0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_size      <= '0;
         r_unsigned  <= 1'b0;
         r_is_write  <= 1'b0;
         r_read_data <= '0;
      end else begin
         if (w_idle && w_req) begin
            r_cnt      <= CW'(WAIT_CYCLES);
            r_addr     <= i_addr[AW+1:0];
            r_wdata    <= i_write_data;
            r_size     <= i_size;
            r_unsigned <= i_load_unsigned;
            r_is_write <= i_mem_write;
         end else if (r_state == S_BUSY) begin
            r_cnt <= r_cnt - CW'(1);
         end
         if (w_enter_done && !w_is_write && !w_mis) r_read_data <= w_load;
      end
   end

   assign o_read_data = r_read_data;
   assign o_ready     = (r_state == S_DONE);
   assign o_error     = (r_state == S_DONE) && misaligned(r_size, r_addr[1:0]);

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: a two-wait-state instance for function and a zero-wait-state
// instance for minimum latency, checked with immediate assertions.
module tb_data_memory;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, rd, wr, uns, rdy, err;
   logic [31:0] addr, wd, rdata;
   logic [1:0]  sz;
   logic        z_rst, z_rd, z_wr, z_uns, z_rdy, z_err;
   logic [31:0] z_addr, z_wd, z_rdata;
   logic [1:0]  z_sz;

   int n_cmp = 0;
   int n_err = 0;
   int ready_seen;

   data_memory #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
      .i_clk(clk), .i_rst(rst), .i_mem_read(rd), .i_mem_write(wr), .i_addr(addr),
      .i_write_data(wd), .i_size(sz), .i_load_unsigned(uns),
      .o_read_data(rdata), .o_ready(rdy), .o_error(err));

   data_memory #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
      .i_clk(clk), .i_rst(z_rst), .i_mem_read(z_rd), .i_mem_write(z_wr), .i_addr(z_addr),
      .i_write_data(z_wd), .i_size(z_sz), .i_load_unsigned(z_uns),
      .o_read_data(z_rdata), .o_ready(z_rdy), .o_error(z_err));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One request; checks latency, error flag, and that ready/error drop after one cycle.
   task automatic op(input string tag, input bit z, input logic w, input logic r,
                     input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                     input logic u, input int exp_lat, input logic exp_err);
      int lat;
      logic e;
      @(negedge clk);
      if (z) begin z_wr = w; z_rd = r; z_addr = a; z_wd = d; z_sz = s; z_uns = u; end
      else   begin wr = w;   rd = r;   addr = a;   wd = d;   sz = s;   uns = u;   end
      @(posedge clk); #1;
      wr = 1'b0; rd = 1'b0; z_wr = 1'b0; z_rd = 1'b0;
      lat = 1;
      while (!(z ? z_rdy : rdy) && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      e = z ? z_err : err;
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
      @(posedge clk); #1;
      chk({tag, "_rdy_drop"}, {31'd0, (z ? z_rdy : rdy)}, 32'd0);
      chk({tag, "_err_drop"}, {31'd0, (z ? z_err : err)}, 32'd0);
   endtask

   initial begin
      rst = 1'b1; rd = 1'b0; wr = 1'b0; uns = 1'b0; addr = '0; wd = '0; sz = '0;
      z_rst = 1'b1; z_rd = 1'b0; z_wr = 1'b0; z_uns = 1'b0; z_addr = '0; z_wd = '0; z_sz = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", {31'd0, rdy}, 32'd0);
      chk("rst_error", {31'd0, err}, 32'd0);
      chk("rst_rdata", rdata, 32'h0000_0000);
      @(negedge clk);
      rst = 1'b0; z_rst = 1'b0;

      op("st_w10", 0, 1, 0, 32'h10, 32'hDEADBEEF, 2'b10, 0, 3, 0);
      chk("st_keeps_rdata", rdata, 32'h0000_0000);
      op("ld_w10", 0, 0, 1, 32'h10, 32'h0, 2'b10, 0, 3, 0);
      chk("ld_w10_data", rdata, 32'hDEADBEEF);

      op("ld_b10s", 0, 0, 1, 32'h10, 32'h0, 2'b00, 0, 3, 0);
      chk("ld_b10s_data", rdata, 32'hFFFFFFEF);
      op("ld_b11s", 0, 0, 1, 32'h11, 32'h0, 2'b00, 0, 3, 0);
      chk("ld_b11s_data", rdata, 32'hFFFFFFBE);
      op("ld_b13s", 0, 0, 1, 32'h13, 32'h0, 2'b00, 0, 3, 0);
      chk("ld_b13s_data", rdata, 32'hFFFFFFDE);
      op("ld_b13u", 0, 0, 1, 32'h13, 32'h0, 2'b00, 1, 3, 0);
      chk("ld_b13u_data", rdata, 32'h000000DE);
      op("ld_h12s", 0, 0, 1, 32'h12, 32'h0, 2'b01, 0, 3, 0);
      chk("ld_h12s_data", rdata, 32'hFFFFDEAD);
      op("ld_h10u", 0, 0, 1, 32'h10, 32'h0, 2'b01, 1, 3, 0);
      chk("ld_h10u_data", rdata, 32'h0000BEEF);

      op("st_b11", 0, 1, 0, 32'h11, 32'hFFFFFF55, 2'b00, 0, 3, 0);
      op("ld_after_b", 0, 0, 1, 32'h10, 32'h0, 2'b10, 0, 3, 0);
      chk("ld_after_b_data", rdata, 32'hDEAD55EF);
      op("st_h12", 0, 1, 0, 32'h12, 32'hABCD1234, 2'b01, 0, 3, 0);
      op("ld_after_h", 0, 0, 1, 32'h10, 32'h0, 2'b10, 0, 3, 0);
      chk("ld_after_h_data", rdata, 32'h123455EF);

      op("mis_ld_w12", 0, 0, 1, 32'h12, 32'h0, 2'b10, 0, 3, 1);
      chk("mis_ld_w12_data", rdata, 32'h123455EF);
      op("mis_ld_h11", 0, 0, 1, 32'h11, 32'h0, 2'b01, 0, 3, 1);
      chk("mis_ld_h11_data", rdata, 32'h123455EF);
      op("mis_ld_rsv", 0, 0, 1, 32'h10, 32'h0, 2'b11, 0, 3, 1);
      chk("mis_ld_rsv_data", rdata, 32'h123455EF);
      op("mis_st_w13", 0, 1, 0, 32'h13, 32'hFFFFFFFF, 2'b10, 0, 3, 1);
      op("ld_after_mis", 0, 0, 1, 32'h10, 32'h0, 2'b10, 0, 3, 0);
      chk("ld_after_mis_data", rdata, 32'h123455EF);

      op("both_hi", 0, 1, 1, 32'h20, 32'hCAFEF00D, 2'b10, 0, 3, 0);
      chk("both_hi_rdata", rdata, 32'h123455EF);
      op("ld_w20", 0, 0, 1, 32'h20, 32'h0, 2'b10, 0, 3, 0);
      chk("ld_w20_data", rdata, 32'hCAFEF00D);

      op("st_alias", 0, 1, 0, 32'h400, 32'hA5A5A5A5, 2'b10, 0, 3, 0);
      op("ld_alias", 0, 0, 1, 32'h000, 32'h0, 2'b10, 0, 3, 0);
      chk("ld_alias_data", rdata, 32'hA5A5A5A5);

      // Store aborted by reset one cycle after acceptance.
      @(negedge clk);
      wr = 1'b1; addr = 32'h10; wd = 32'h11111111; sz = 2'b10;
      @(posedge clk); #1;
      wr = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_ready", {31'd0, rdy}, 32'd0);
      chk("abort_error", {31'd0, err}, 32'd0);
      chk("abort_rdata", rdata, 32'h0000_0000);
      @(negedge clk);
      rst = 1'b0;
      ready_seen = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (rdy) ready_seen++;
      end
      chk("abort_no_ready", 32'(ready_seen), 32'd0);
      op("ld_after_abort", 0, 0, 1, 32'h10, 32'h0, 2'b10, 0, 3, 0);
      chk("ld_after_abort_data", rdata, 32'h123455EF);

      // Reset coinciding with the commit edge also drops the store.
      @(negedge clk);
      wr = 1'b1; addr = 32'h10; wd = 32'h22222222; sz = 2'b10;
      @(posedge clk); #1;
      wr = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("commit_rst_ready", {31'd0, rdy}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      op("ld_after_crst", 0, 0, 1, 32'h10, 32'h0, 2'b10, 0, 3, 0);
      chk("ld_after_crst_data", rdata, 32'h123455EF);

      op("z_st_w08", 1, 1, 0, 32'h08, 32'h12345678, 2'b10, 0, 1, 0);
      op("z_ld_w08", 1, 0, 1, 32'h08, 32'h0, 2'b10, 0, 1, 0);
      chk("z_ld_w08_data", z_rdata, 32'h12345678);
      op("z_ld_b09", 1, 0, 1, 32'h09, 32'h0, 2'b00, 0, 1, 0);
      chk("z_ld_b09_data", z_rdata, 32'h00000056);
      op("z_mis_h09", 1, 0, 1, 32'h09, 32'h0, 2'b01, 0, 1, 1);
      chk("z_mis_h09_data", z_rdata, 32'h00000056);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/data_memory.md
# data_memory

Word-organised data memory for the multi-cycle MIPS datapath, sitting directly upstream of the memory data register that latches `read_data` for write-back. It serves one load or store at a time with a configurable number of wait states, supports byte/halfword/word access with little-endian lane selection and sign/zero extension on loads, and flags misaligned accesses instead of performing them. A one-cycle `ready` pulse tells the control unit when the access is complete and `read_data` is valid.

## Interface
- `DEPTH_WORDS`, 256: number of 32-bit words; power of two, at least 4.
- `WAIT_CYCLES`, 2: busy cycles between request acceptance and completion; 0 is legal.
- `clk`  input  1  single clock; all state changes on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `mem_read`  input  1  load request; sampled only in IDLE.
- `mem_write`  input  1  store request; sampled only in IDLE; wins if both are high.
- `addr`  input  32  byte address.
- `write_data`  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `size`  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
- `load_unsigned`  input  1  1 = zero-extend sub-word loads, 0 = sign-extend.
- `read_data`  output  32  load result; holds value until next successful load completes.
- `ready`  output  1  one-cycle completion pulse, for loads and stores.
- `error`  output  1  valid with `ready`; 1 = misaligned or reserved-size request.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: on an edge with `mem_read | mem_write`, capture `addr`, `write_data`, `size`, `load_unsigned`, op type (write if `mem_write`), wait counter = `WAIT_CYCLES`, then go to BUSY (or directly to DONE if `WAIT_CYCLES` = 0).
- BUSY: decrement counter each edge; at 1 go to DONE. Inputs ignored; captured copies are used.
- DONE: `ready` = 1 for exactly this cycle; next edge returns to IDLE. Back-to-back requests: a request held high is accepted on the edge leaving DONE? No: the edge leaving DONE only moves to IDLE; acceptance requires being in IDLE, so minimum spacing is one IDLE cycle.
- Word index = captured `addr[log2(DEPTH_WORDS)+1:2]`; higher address bits ignored (wrap-around).
- Misaligned: halfword with `addr[0]` = 1, word with `addr[1:0]` ≠ 0, any `size` = 11. Such requests complete with the same latency, `error` = 1, memory unchanged, `read_data` unchanged.
- Store commit: on the edge entering DONE; only the addressed lanes are written (byte: lane `addr[1:0]`; half: lanes 0-1 or 2-3 by `addr[1]`; word: all four).
- Load: selected lanes read on the edge entering DONE, extended per `load_unsigned`, registered into `read_data`.
- Stores never change `read_data`.

## Timing
- Reset values: state IDLE, `ready` 0, `error` 0, `read_data` 0x00000000, counter 0. Memory array not cleared.
- Latency: acceptance edge at cycle 0 → `ready` high during cycle `WAIT_CYCLES`+1 (cycle 1 when `WAIT_CYCLES` = 0).
- `read_data` and `error` become valid in the same cycle `ready` rises; `error` returns to 0 with `ready`.
- `rst` asserted in any state: next edge forces reset values; an in-flight store whose commit edge has not occurred is dropped; reset on the commit edge itself also drops the store (reset has priority).
- Requests presented while BUSY or DONE are ignored, not queued.

## Test plan
- Word store 0xDEADBEEF at 0x10, then word load 0x10 (`WAIT_CYCLES` = 2) → `ready` 3 cycles after each acceptance, `read_data` = 0xDEADBEEF, `error` 0.
- Byte loads from 0x10, 0x11, 0x13 signed → 0xFFFFFFEF, 0xFFFFFFBE, 0xFFFFFFDE; unsigned 0x13 → 0x000000DE; halfword 0x12 signed → 0xFFFFDEAD.
- Byte store 0x55 to 0x11 over 0xDEADBEEF, word load 0x10 → 0xDEAD55EF; halfword store 0x1234 at 0x12 → 0x123455EF.
- Word load at 0x12 and halfword load at 0x11 after a good load → `ready` with `error` 1, `read_data` unchanged; word store at 0x13 → memory unchanged on readback.
- `mem_read` and `mem_write` both high → store performed, `read_data` unchanged; address 0x400 with `DEPTH_WORDS` = 256 aliases 0x000.
- Word store accepted, `rst` pulsed one cycle later → no `ready`, outputs at reset values, readback shows old word; `WAIT_CYCLES` = 0 build shows `ready` one cycle after acceptance.
